// File: rtl/rock_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rock_pkg
// Description : Types and constants shared by the rocking controller blocks
//               (actuator, PWM stage and the path-finding decision logic).
// Revision    : 1.0 - initial release
// ============================================================================
package rock_pkg;

    // Swing sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BACK = 2'd2,
        STOP = 2'd3
    } rock_state_t;

    // Level widths shared with the decision logic
    localparam int C_FREQ_W   = 8;
    localparam int C_AMP_W    = 6;

    // Levels loaded at reset
    localparam int C_FREQ_DEF = 50;
    localparam int C_AMP_DEF  = 32;

endpackage : rock_pkg
`default_nettype wire

// File: rtl/rock_pwm.sv
`default_nettype none
// ============================================================================
// Module      : rock_pwm
// Description : Motor magnitude PWM. A free-running ramp is compared against
//               the amplitude level; the result is registered, so motor_pwm
//               lags the compare by one clock. Output is forced low while the
//               swing sequencer is inactive.
// Revision    : 1.0 - initial release
// ============================================================================
module rock_pwm #(
    parameter int AMP_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AMP_W-1:0] amp_level,
    input  logic             active,
    output logic             motor_pwm
);

    logic [AMP_W-1:0] r_cnt;

    // Free-running ramp, wraps naturally at 2^AMP_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + AMP_W'(1);
        end
    end

    // Registered compare; amp_level = 0 can never win so the output stays low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor_pwm <= 1'b0;
        end else begin
            motor_pwm <= active && (r_cnt < amp_level);
        end
    end

endmodule : rock_pwm
`default_nettype wire

// File: rtl/rock_actuator.sv
`default_nettype none
// ============================================================================
// Module      : rock_actuator
// Description : Command-executing end of the rocking controller. Runs the
//               forward/back swing sequence at the current frequency level,
//               collects adjust requests as sticky flags and applies them at
//               the end of each back swing, and drives the cradle motor with a
//               direction bit plus a PWM magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
module rock_actuator
    import rock_pkg::*;
#(
    parameter int PRESCALE  = 1000,
    parameter int FREQ_W    = C_FREQ_W,
    parameter int AMP_W     = C_AMP_W,
    parameter int FREQ_MIN  = 4,
    parameter int FREQ_MAX  = 200,
    parameter int FREQ_DEF  = C_FREQ_DEF,
    parameter int FREQ_STEP = 2,
    parameter int AMP_DEF   = C_AMP_DEF,
    parameter int AMP_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              f_plus,
    input  logic              f_min,
    input  logic              a_plus,
    input  logic              a_min,
    output logic              motor_dir,
    output logic              motor_pwm,
    output logic              cycle_done,
    output logic              cmd_ack,
    output logic              limit_hit,
    output logic [FREQ_W-1:0] freq_level,
    output logic [AMP_W-1:0]  amp_level
);

    // ------------------------------------------------------------------
    // Widths and constants. Level arithmetic is one bit wider than the
    // level itself so a step past either end is seen instead of wrapping.
    // ------------------------------------------------------------------
    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int FW1  = FREQ_W + 1;
    localparam int AW1  = AMP_W + 1;

    localparam logic [PS_W-1:0] C_PS_LAST     = PS_W'(PRESCALE - 1);
    localparam logic [FW1-1:0]  C_HP_BASE     = FW1'(FREQ_MAX + FREQ_MIN);
    localparam logic [FW1-1:0]  C_FMAX        = FW1'(FREQ_MAX);
    localparam logic [FW1-1:0]  C_FSTEP       = FW1'(FREQ_STEP);
    localparam logic [FW1-1:0]  C_FMIN_P_STEP = FW1'(FREQ_MIN + FREQ_STEP);
    localparam logic [AW1-1:0]  C_AMAX        = AW1'((1 << AMP_W) - 1);
    localparam logic [AW1-1:0]  C_ASTEP       = AW1'(AMP_STEP);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    rock_state_t       r_state;
    logic [PS_W-1:0]   r_presc;
    logic [FW1-1:0]    r_swing;
    logic              r_pend_fp;
    logic              r_pend_fm;
    logic              r_pend_ap;
    logic              r_pend_am;

    logic              w_tick;
    logic              w_presc_clr;
    logic [FW1-1:0]    w_hp;
    logic              w_swing_end;
    logic              w_apply;
    logic              w_any_pend;

    logic [FW1-1:0]    w_f_up;
    logic [FW1-1:0]    w_f_dn;
    logic [AW1-1:0]    w_a_up;
    logic [AW1-1:0]    w_a_dn;
    logic [FREQ_W-1:0] w_freq_next;
    logic [AMP_W-1:0]  w_amp_next;
    logic              w_f_clamp;
    logic              w_a_clamp;

    // ------------------------------------------------------------------
    // Swing timing. The half period shrinks as the level rises; since the
    // level only moves at the end of a back swing, a new value first
    // shapes the following forward swing.
    // ------------------------------------------------------------------
    assign w_tick      = (r_presc == C_PS_LAST);
    assign w_hp        = C_HP_BASE - {1'b0, freq_level};
    assign w_swing_end = w_tick && (r_swing == (w_hp - FW1'(1)));
    assign w_apply     = ((r_state == BACK) || (r_state == STOP)) && w_swing_end;
    assign w_any_pend  = r_pend_fp | r_pend_fm | r_pend_ap | r_pend_am;

    // Prescaler restarts on entry to STOP so the back stroke gets a full half period
    assign w_presc_clr = (r_state == IDLE) || ((r_state == FWD) && !enable);

    // Prescaler: divides clk down to swing ticks while a swing is in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_presc_clr || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next levels from the pending flags. Opposing requests cancel.
    // ------------------------------------------------------------------
    assign w_f_up = {1'b0, freq_level} + C_FSTEP;
    assign w_f_dn = {1'b0, freq_level} - C_FSTEP;
    assign w_a_up = {1'b0, amp_level} + C_ASTEP;
    assign w_a_dn = {1'b0, amp_level} - C_ASTEP;

    // Frequency step with clamping to FREQ_MIN..FREQ_MAX
    always_comb begin
        w_freq_next = freq_level;
        w_f_clamp   = 1'b0;
        if (r_pend_fp && !r_pend_fm) begin
            if (w_f_up > C_FMAX) begin
                w_freq_next = FREQ_W'(FREQ_MAX);
                w_f_clamp   = 1'b1;
            end else begin
                w_freq_next = w_f_up[FREQ_W-1:0];
            end
        end else if (r_pend_fm && !r_pend_fp) begin
            if ({1'b0, freq_level} < C_FMIN_P_STEP) begin
                w_freq_next = FREQ_W'(FREQ_MIN);
                w_f_clamp   = 1'b1;
            end else begin
                w_freq_next = w_f_dn[FREQ_W-1:0];
            end
        end
    end

    // Amplitude step with clamping to the full 0..2^AMP_W-1 range
    always_comb begin
        w_amp_next = amp_level;
        w_a_clamp  = 1'b0;
        if (r_pend_ap && !r_pend_am) begin
            if (w_a_up > C_AMAX) begin
                w_amp_next = C_AMAX[AMP_W-1:0];
                w_a_clamp  = 1'b1;
            end else begin
                w_amp_next = w_a_up[AMP_W-1:0];
            end
        end else if (r_pend_am && !r_pend_ap) begin
            if ({1'b0, amp_level} < C_ASTEP) begin
                w_amp_next = '0;
                w_a_clamp  = 1'b1;
            end else begin
                w_amp_next = w_a_dn[AMP_W-1:0];
            end
        end
    end

    // Sticky request flags; on the apply clock they reload from the live
    // inputs so a request arriving right then carries into the next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_fp <= 1'b0;
            r_pend_fm <= 1'b0;
            r_pend_ap <= 1'b0;
            r_pend_am <= 1'b0;
        end else if (w_apply) begin
            r_pend_fp <= f_plus;
            r_pend_fm <= f_min;
            r_pend_ap <= a_plus;
            r_pend_am <= a_min;
        end else begin
            r_pend_fp <= r_pend_fp | f_plus;
            r_pend_fm <= r_pend_fm | f_min;
            r_pend_ap <= r_pend_ap | a_plus;
            r_pend_am <= r_pend_am | a_min;
        end
    end

    // Swing sequencer with registered direction, pulses and level registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_swing    <= '0;
            motor_dir  <= 1'b0;
            cycle_done <= 1'b0;
            cmd_ack    <= 1'b0;
            limit_hit  <= 1'b0;
            freq_level <= FREQ_W'(FREQ_DEF);
            amp_level  <= AMP_W'(AMP_DEF);
        end else begin
            cycle_done <= 1'b0;
            cmd_ack    <= 1'b0;
            limit_hit  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_swing   <= '0;
                    motor_dir <= 1'b0;
                    if (enable) begin
                        r_state <= FWD;
                    end
                end
                FWD: begin
                    if (!enable) begin
                        // Abandon the forward stroke but still complete a full return
                        r_state   <= STOP;
                        r_swing   <= '0;
                        motor_dir <= 1'b1;
                    end else if (w_swing_end) begin
                        r_state   <= BACK;
                        r_swing   <= '0;
                        motor_dir <= 1'b1;
                    end else if (w_tick) begin
                        r_swing <= r_swing + FW1'(1);
                    end
                end
                BACK, STOP: begin
                    if (w_swing_end) begin
                        cycle_done <= 1'b1;
                        cmd_ack    <= w_any_pend;
                        limit_hit  <= w_f_clamp | w_a_clamp;
                        freq_level <= w_freq_next;
                        amp_level  <= w_amp_next;
                        r_swing    <= '0;
                        motor_dir  <= 1'b0;
                        // STOP always parks; enable seen during STOP is ignored
                        r_state    <= ((r_state == BACK) && enable) ? FWD : IDLE;
                    end else if (w_tick) begin
                        r_swing <= r_swing + FW1'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_swing   <= '0;
                    motor_dir <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PWM magnitude stage
    // ------------------------------------------------------------------
    rock_pwm #(
        .AMP_W (AMP_W)
    ) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .amp_level (amp_level),
        .active    (r_state != IDLE),
        .motor_pwm (motor_pwm)
    );

endmodule : rock_actuator
`default_nettype wire

// File: doc/rock_actuator.md
Name: rock_actuator

Overview:
- Command-executing end of the rocking controller.
- Accepts the adjust requests raised by the path-finding decision logic: frequency up/down and amplitude up/down.
- Holds the current frequency and amplitude settings and drives the cradle motor with a direction signal and a PWM magnitude.
- Reports each completed rock cycle so the decision logic can re-evaluate.

Parameters:
PRESCALE, 1000, clk cycles per swing tick (>=2)
FREQ_W, 8, width of frequency level
AMP_W, 6, width of amplitude level and PWM counter
FREQ_MIN, 4, lowest frequency level
FREQ_MAX, 200, highest frequency level
FREQ_DEF, 50, frequency level after reset
FREQ_STEP, 2, frequency change per accepted command
AMP_DEF, 32, amplitude level after reset
AMP_STEP, 4, amplitude change per accepted command (amplitude range 0..2^AMP_W-1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
enable  in  1  rocking requested
f_plus  in  1  request frequency increase, sampled every clk
f_min  in  1  request frequency decrease
a_plus  in  1  request amplitude increase
a_min  in  1  request amplitude decrease
motor_dir  out  1  0 = forward swing, 1 = back swing
motor_pwm  out  1  motor drive PWM
cycle_done  out  1  one-clk pulse at end of each back swing
cmd_ack  out  1  one-clk pulse when pending requests are applied
limit_hit  out  1  one-clk pulse when an applied step was clamped
freq_level  out  FREQ_W  current frequency setting
amp_level  out  AMP_W  current amplitude setting

Behaviour:
- Reset values (async): state IDLE; all counters 0; pending flags 0; motor_dir 0; motor_pwm 0; cycle_done, cmd_ack, limit_hit 0; freq_level FREQ_DEF; amp_level AMP_DEF.
- Prescaler:
  - Counts 0..PRESCALE-1 while state != IDLE; tick when count = PRESCALE-1.
  - Cleared in IDLE.
- Half period: HP = FREQ_MAX + FREQ_MIN - freq_level, in ticks. Higher level gives a shorter swing. HP is always >= FREQ_MIN.
- FSM states IDLE, FWD, BACK, STOP:
  - IDLE -> FWD when enable=1. Swing counter 0; motor_dir 0.
  - FWD: on the tick where swing count = HP-1, go to BACK; counter 0; motor_dir 1.
  - BACK: on the tick where swing count = HP-1:
    - assert cycle_done;
    - apply pending requests;
    - go to FWD if enable=1, else IDLE; motor_dir 0.
  - enable=0 during FWD: go to STOP. STOP behaves as BACK, except it always ends in IDLE.
  - enable=0 during BACK: finish the swing, then go to IDLE. A cycle is never truncated.
  - enable re-asserted during STOP: ignored until IDLE is reached.
- Request capture:
  - Each request input sets a sticky pending flag on any clk where it is high, in any state.
  - Flags clear on the apply cycle.
  - A request high on the apply cycle itself is kept for the next cycle.
- Apply rule (end of BACK/STOP only; nothing is applied in IDLE or mid-cycle):
  - Frequency:
    - f_plus pending only: freq_level = min(freq_level + FREQ_STEP, FREQ_MAX).
    - f_min pending only: freq_level = max(freq_level - FREQ_STEP, FREQ_MIN).
    - Both pending: no change.
  - Amplitude: same rule using a_plus/a_min, range 0..2^AMP_W-1, step AMP_STEP.
  - Arithmetic is done one bit wider, so there is no wrap-around.
  - cmd_ack pulses if any flag was pending.
  - limit_hit pulses if any clamp altered the result.
  - New levels take effect from the first tick of the next FWD.
- PWM:
  - Free-running AMP_W-bit counter on clk.
  - motor_pwm = (state in FWD/BACK/STOP) & (pwm_cnt < amp_level), registered, so it lags the compare by 1 clk.
  - amp_level = 0 gives constant 0.
- Reset mid-swing: immediate return to reset values. Pending requests are lost.

Decomposition:
- Shared package rock_pkg holds:
  - the state typedef (IDLE, FWD, BACK, STOP);
  - default constants FREQ_DEF and AMP_DEF;
  - the shared level widths used by the decision logic.
- One sub-module, rock_pwm: counter and registered compare, with inputs amp_level and active, output motor_pwm.
- The FSM, prescaler and request capture stay in the top level.

Test Plan:
- PRESCALE=2 with defaults, reset released, enable=1:
  - HP = 154 ticks, so motor_dir is 0 for 308 clk then 1 for 308 clk;
  - cycle_done pulses at clk 616; freq_level stays 50.
- One-clk f_plus pulse mid-FWD -> at end of first BACK: cmd_ack=1, freq_level 52; next half period is 152 ticks; limit_hit=0.
- f_plus and f_min both pulsed in the same cycle -> cmd_ack=1, freq_level unchanged at 50.
- freq_level preset near the top: step f_plus until freq_level=200, then one more f_plus -> freq_level 200, limit_hit=1. Repeat with a_min from amp 4 -> 0, then a_min again -> 0 with limit_hit=1; motor_pwm stays 0.
- enable dropped 10 ticks into FWD -> motor_dir goes 1 immediately (STOP) for a full HP. Then cycle_done fires, the FSM goes to IDLE and motor_pwm is 0. enable=1 during STOP has no effect until IDLE.
- Async reset asserted mid-BACK with a_plus pending -> outputs return to reset values in the same clk. After release, amp_level=32 and no cmd_ack at the first cycle end.
